display_varredura: RTL and testbench

Multiplexed multi-digit seven-segment display driver for the board's common-anode displays. It latches a packed hexadecimal value on a load strobe and scans one digit at a time at a programmable rate. Each scanned digit is decoded to active-low segments. Optional leading-zero blanking and a blink mode are provided. It sits between the datapath and the display pins and generalises the single-digit hex decoder to N time-multiplexed digits.

---
 rtl/display_varredura.sv | 110 +++++++++++
 tb/tb_display_varredura.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/display_varredura.sv
// Time-multiplexed N-digit hex driver for common-anode seven-segment displays.
// Each output is registered from the current scan state, which adds one cycle of latency.
module display_varredura #(
    parameter int DIGITOS       = 4,
    parameter int DIV_VARREDURA = 50000,
    parameter int DIV_PISCA     = 25
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   carregar,
    input  logic [4*DIGITOS-1:0]   valor,
    input  logic                   apagar_zeros,
    input  logic                   piscar,
    output logic [DIGITOS-1:0]     anodo,
    output logic [6:0]             segmentos,
    output logic                   quadro
);
    localparam int IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
    localparam int PW = (DIV_VARREDURA > 1) ? $clog2(DIV_VARREDURA) : 1;
    localparam int FW = (DIV_PISCA > 1) ? $clog2(DIV_PISCA) : 1;

    logic [4*DIGITOS-1:0] sombra;
    logic [PW-1:0]        pre;
    logic [IW-1:0]        idx;
    logic [FW-1:0]        quadros;
    logic                 oculto;
    logic [DIGITOS-1:0]   zeros_acima;
    logic                 fim_pre, fim_idx, virada, apaga;
    logic [3:0]           nib;
    logic [6:0]           seg_prox;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // zeros_acima[i] is set when digit i and every more significant digit are zero
    genvar gi;
    generate
        for (gi = 0; gi < DIGITOS; gi++) begin : g_zero
            assign zeros_acima[gi] = (sombra[4*DIGITOS-1:4*gi] == '0);
        end
    endgenerate

    assign fim_pre = (pre == PW'(DIV_VARREDURA - 1));
    assign fim_idx = (idx == IW'(DIGITOS - 1));
    assign virada  = fim_pre && fim_idx;

    always_comb begin
        nib   = 4'h0;
        apaga = 1'b0;
        for (int i = 0; i < DIGITOS; i++) begin
            if (idx == IW'(i)) begin
                nib   = sombra[4*i +: 4];
                apaga = apagar_zeros && (i > 0) && zeros_acima[i];
            end
        end
        seg_prox = (apaga || (piscar && oculto)) ? 7'b1111111 : hex7(nib);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sombra    <= '0;
            pre       <= '0;
            idx       <= '0;
            quadros   <= '0;
            oculto    <= 1'b0;
            anodo     <= ~DIGITOS'(1);
            segmentos <= 7'b1000000;
            quadro    <= 1'b0;
        end else begin
            if (carregar)
                sombra <= valor;
            if (fim_pre) begin
                pre <= '0;
                idx <= fim_idx ? '0 : idx + IW'(1);
                // blink phase advances once per DIV_PISCA complete frames
                if (fim_idx) begin
                    if (quadros == FW'(DIV_PISCA - 1)) begin
                        quadros <= '0;
                        oculto  <= ~oculto;
                    end else begin
                        quadros <= quadros + FW'(1);
                    end
                end
            end else begin
                pre <= pre + PW'(1);
            end
            anodo     <= ~(DIGITOS'(1) << idx);
            segmentos <= seg_prox;
            quadro    <= virada;
        end
    end
endmodule

// File: tb/tb_display_varredura.sv
// Scoreboard bench for display_varredura: a cycle model pushes the expected outputs
// for each edge, and they are popped and compared just after that edge.
module tb_display_varredura;
    localparam int D  = 4;
    localparam int DV = 2;
    localparam int DP = 2;

    logic            clock = 1'b0;
    logic            reset, carregar, apagar_zeros, piscar;
    logic [4*D-1:0]  valor;
    logic [D-1:0]    anodo;
    logic [6:0]      segmentos;
    logic            quadro;

    display_varredura #(.DIGITOS(D), .DIV_VARREDURA(DV), .DIV_PISCA(DP)) dut (
        .clock(clock), .reset(reset), .carregar(carregar), .valor(valor),
        .apagar_zeros(apagar_zeros), .piscar(piscar),
        .anodo(anodo), .segmentos(segmentos), .quadro(quadro)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [D-1:0] a;
        logic [6:0]   s;
        logic         q;
    } saida_t;

    saida_t      fila[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [6:0]  tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // reference model state
    logic [4*D-1:0] m_sombra = '0;
    int             m_pre = 0, m_idx = 0, m_quadros = 0;
    bit             m_oculto = 1'b0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        saida_t e;
        logic [4*D-1:0] acima;
        bit virada;
        if (reset) begin
            e = '{a: 4'b1110, s: 7'h40, q: 1'b0};
            m_sombra = '0; m_pre = 0; m_idx = 0; m_quadros = 0; m_oculto = 1'b0;
        end else begin
            acima  = m_sombra >> (4 * m_idx);
            virada = (m_pre == DV - 1) && (m_idx == D - 1);
            e.a = 4'hF ^ (4'd1 << m_idx);
            e.s = tab[acima[3:0]];
            if (apagar_zeros && m_idx > 0 && acima == 0) e.s = 7'h7F;
            if (piscar && m_oculto) e.s = 7'h7F;
            e.q = virada;
            if (carregar) m_sombra = valor;
            if (m_pre == DV - 1) begin
                m_pre = 0;
                m_idx = (m_idx + 1) % D;
                if (virada) begin
                    m_quadros++;
                    if (m_quadros == DP) begin
                        m_quadros = 0;
                        m_oculto = !m_oculto;
                    end
                end
            end else begin
                m_pre++;
            end
        end
        fila.push_back(e);
        @(posedge clock);
        #1;
        e = fila.pop_front();
        chk("anodo", 16'(anodo), 16'(e.a));
        chk("segmentos", 16'(segmentos), 16'(e.s));
        chk("quadro", 16'(quadro), 16'(e.q));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        bit achou;
        reset = 1'b1; carregar = 1'b0; valor = '0; apagar_zeros = 1'b0; piscar = 1'b0;
        run(2);
        chk("rst_anodo", 16'(anodo), 16'b1110);
        chk("rst_seg", 16'(segmentos), 16'h40);
        chk("rst_quadro", 16'(quadro), 16'h0);
        reset = 1'b0;
        run(20);

        // hex decode, no blanking
        valor = 16'h12AF; carregar = 1'b1; step(); carregar = 1'b0;
        run(16);

        // leading-zero blanking, then an all-zero value
        apagar_zeros = 1'b1;
        valor = 16'h0030; carregar = 1'b1; step(); carregar = 1'b0;
        run(16);
        valor = 16'h0000; carregar = 1'b1; step(); carregar = 1'b0;
        run(16);
        apagar_zeros = 1'b0;
        valor = 16'h8E5C; carregar = 1'b1; step(); carregar = 1'b0;

        // blink across several half-periods
        piscar = 1'b1;
        run(80);

        // reset mid-frame while the display is hidden on digit 2
        achou = 1'b0;
        for (int k = 0; k < 200 && !achou; k++) begin
            if (m_idx == 2 && m_oculto && m_pre == 0) achou = 1'b1;
            else step();
        end
        chk("seek_hidden_idx2", 16'(achou), 16'h1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("midrst_anodo", 16'(anodo), 16'b1110);
        chk("midrst_seg", 16'(segmentos), 16'h40);
        chk("midrst_quadro", 16'(quadro), 16'h0);
        step();
        chk("midrst_visible", 16'(segmentos), 16'h40);
        piscar = 1'b0;

        // reset takes priority over load
        run(3);
        reset = 1'b1; carregar = 1'b1; valor = 16'hFFFF; step();
        reset = 1'b0; carregar = 1'b0;
        step();
        chk("rst_over_load", 16'(segmentos), 16'h40);
        run(8);

        // random traffic, including loads that land on a prescaler terminal count
        for (int k = 0; k < 400; k++) begin
            carregar = ($urandom_range(0, 5) == 0);
            valor    = 16'($urandom);
            if ($urandom_range(0, 3) == 0) valor = valor & 16'h00FF;
            if ($urandom_range(0, 15) == 0) apagar_zeros = ~apagar_zeros;
            if ($urandom_range(0, 31) == 0) piscar = ~piscar;
            reset = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
